fht_rd_unload: RTL and testbench
================================

FHT_RD_UNLOAD -- requirements
Module: fht_rd_unload

Interface
REQ-001 SHALL have parameter D_BIT, default `D_BIT, meaning the RAM word width (signed).
REQ-002 SHALL have parameter A_BIT, default `A_BIT, meaning the bank address width; BANK_SIZE = 2**A_BIT.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning the RAM read latency in cycles from address to data (legal range 1..3).
REQ-004 SHALL have ports, in this order:
- iCLK  in  1  clock; all logic on rising edge.
- iRESET  in  1  reset; asynchronous, active-high.
- iSTART  in  1  one-cycle unload request.
- iFHT_RDY  in  1  FHT result-valid level, from fht_top oRDY.
- oADDR_RD  out  A_BIT  row address, driven to iADDR_RD_0..3 of fht_top.
- iDATA_0..iDATA_3  in  D_BIT each  bank read data, from fht_top oDATA_0..3.
- oDATA  out  D_BIT  serialized result word.
- oIDX  out  A_BIT+2  word index = 4*row + bank.
- oVALID  out  1  oDATA/oIDX valid.
- iREADY  in  1  sink accepts the word.
- oLAST  out  1  high with the final word (oIDX = 4*BANK_SIZE-1).
- oBUSY  out  1  unload in progress.
- oDONE  out  1  one-cycle pulse after the final word is accepted.

Function
REQ-005 SHALL implement FSM IDLE -> RUN on iSTART & iFHT_RDY; RUN -> IDLE when the final word is accepted; no other states.
REQ-006 SHALL ignore iSTART in RUN, and in IDLE when iFHT_RDY = 0 (no state change).
REQ-007 SHALL assert oBUSY in RUN only; oBUSY rises the cycle after the accepted iSTART.
REQ-008 SHALL issue row reads 0..BANK_SIZE-1 in ascending order, one address per cycle at most, driving oADDR_RD with that row.
REQ-009 SHALL capture iDATA_0..3 into a row slot exactly RD_LAT cycles after the row address is issued.
REQ-010 SHALL hold two row slots (ping-pong); a new row read SHALL issue only when (occupied slots + in-flight reads) < 2.
REQ-011 SHALL serialize each row as bank 0,1,2,3; oIDX SHALL equal 4*row + bank.
REQ-012 SHALL follow valid/ready: a word transfers when oVALID & iREADY; with oVALID high and iREADY low, oDATA/oIDX/oLAST SHALL hold stable.
REQ-013 SHALL sustain one word per cycle with iREADY held high after the first word; first oVALID no later than RD_LAT+2 cycles after accepted iSTART.
REQ-014 SHALL never drop or duplicate a word under any iREADY pattern; exactly 4*BANK_SIZE transfers per unload.
REQ-015 SHALL pulse oDONE for one cycle the cycle after the final transfer, simultaneously with oBUSY falling.
REQ-016 SHALL accept a new iSTART the cycle oDONE is high if iFHT_RDY = 1.
REQ-017 SHALL continue a running unload if iFHT_RDY falls mid-unload (data assumed frozen).
REQ-018 SHALL hold oADDR_RD at the last issued row when no read is issued.

Reset
REQ-019 SHALL, while iRESET = 1, force IDLE and set oADDR_RD, oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE to 0, clear both slots and in-flight counters.
REQ-020 SHALL, on reset mid-unload, abandon the unload; data captured for in-flight reads after reset release SHALL be discarded.

Configuration
REQ-021 SHALL honour macro FHT_UNLOAD_SAT_EN: when defined, oDATA is saturated to signed D_BIT-1 range (-2**(D_BIT-2) .. 2**(D_BIT-2)-1) and sign-extended to D_BIT; when undefined, oDATA is the raw D_BIT word.

Verification (D_BIT=16, A_BIT=8, RD_LAT=2)
REQ-022 Banks preloaded with word = 4*addr+bank, iREADY=1, pulse iSTART with iFHT_RDY=1 -> 1024 words, oIDX 0..1023 in order, oDATA = oIDX, oLAST on 1023, oDONE once, total run <= 1024+5 cycles.
REQ-023 Same data, iREADY random 50% -> identical 1024-word sequence, outputs stable on stall cycles, no drop/duplicate.
REQ-024 iSTART with iFHT_RDY=0, and iSTART pulsed mid-unload -> first ignored (oBUSY stays 0), second has no effect on sequence.
REQ-025 iRESET pulse at word 300 -> all outputs 0 next edge; fresh iSTART restarts from oIDX 0.
REQ-026 Bank 2 row 5 = 20000, bank 3 row 5 = -20000 -> with FHT_UNLOAD_SAT_EN: oIDX 22 gives 16383, oIDX 23 gives -16384; without: 20000 / -20000.
REQ-027 iSTART asserted on the oDONE cycle -> second unload starts, oIDX restarts at 0, no gap beyond RD_LAT+2 cycles.

Source files
------------

// File: rtl/fht_rd_unload.sv
// fht_rd_unload: reads the four FHT result banks row by row and streams the
// words out in index order (4*row + bank) over a valid/ready interface.
// Optional feature macro: FHT_UNLOAD_SAT_EN saturates oDATA to the signed
// D_BIT-1 range, sign-extended back to D_BIT.
`ifndef D_BIT
`define D_BIT 16
`endif
`ifndef A_BIT
`define A_BIT 8
`endif

module fht_rd_unload #(
  parameter int D_BIT  = `D_BIT,
  parameter int A_BIT  = `A_BIT,
  parameter int RD_LAT = 2
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iFHT_RDY,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT+1:0] oIDX,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic             oBUSY,
  output logic             oDONE
);

  // oADDR_RD is registered, so data is sampled RD_LAT cycles after the
  // address appears on the port, i.e. RD_LAT+1 edges after the issue edge.
  localparam int PIPE = RD_LAT + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [A_BIT:0]   rd_row_q;
  logic [PIPE-1:0]  pipe_q, pipe_d;
  logic [1:0]       inflight_q;
  logic [1:0]       slot_vld_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [D_BIT-1:0] slot_q [2][4];
  logic [1:0]       bank_q;
  logic [A_BIT-1:0] out_row_q;
  logic             done_q;

  logic             start_ok, issue, cap, xfer, row_free, final_xfer;
  logic [2:0]       credit;
  logic [D_BIT-1:0] raw;

  // Handshake, read-issue and capture decisions
  always_comb begin
    start_ok   = (state_q == IDLE) && iSTART && iFHT_RDY;
    oVALID     = slot_vld_q[rd_ptr_q];
    xfer       = oVALID && iREADY;
    row_free   = xfer && (bank_q == 2'd3);
    oIDX       = {out_row_q, bank_q};
    oLAST      = oVALID && (&oIDX);
    final_xfer = xfer && oLAST;
    // A slot emptied by this cycle's transfer is counted as free so the
    // next row read overlaps the drain; needed to keep one word per cycle.
    credit     = {2'b00, slot_vld_q[0]} + {2'b00, slot_vld_q[1]}
               + {1'b0, inflight_q} - {2'b00, row_free};
    issue      = start_ok ||
                 ((state_q == RUN) && !rd_row_q[A_BIT] && (credit < 3'd2));
    cap        = pipe_q[PIPE-1];
    pipe_d     = pipe_q << 1;
    pipe_d[0]  = issue;
    oBUSY      = (state_q == RUN);
    oDONE      = done_q;
    raw        = slot_q[rd_ptr_q][bank_q];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (final_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Row address generation and read-latency tracking
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oADDR_RD   <= '0;
      rd_row_q   <= '0;
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      inflight_q <= inflight_q + {1'b0, issue} - {1'b0, cap};
      if (issue) begin
        if (start_ok) begin
          oADDR_RD <= '0;
          rd_row_q <= {{A_BIT{1'b0}}, 1'b1};
        end else begin
          oADDR_RD <= rd_row_q[A_BIT-1:0];
          rd_row_q <= rd_row_q + 1'b1;
        end
      end
    end
  end

  // Ping-pong row slots: capture on read return, release after bank 3 leaves
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int unsigned s = 0; s < 2; s++)
        for (int unsigned b = 0; b < 4; b++)
          slot_q[s][b] <= '0;
      slot_vld_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      bank_q     <= '0;
      out_row_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= final_xfer;
      if (xfer) bank_q <= bank_q + 2'd1;
      if (row_free) begin
        slot_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= ~rd_ptr_q;
        out_row_q            <= out_row_q + 1'b1;
      end
      if (cap) begin
        slot_q[wr_ptr_q][0]  <= iDATA_0;
        slot_q[wr_ptr_q][1]  <= iDATA_1;
        slot_q[wr_ptr_q][2]  <= iDATA_2;
        slot_q[wr_ptr_q][3]  <= iDATA_3;
        slot_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q             <= ~wr_ptr_q;
      end
    end
  end

`ifdef FHT_UNLOAD_SAT_EN
  localparam logic signed [D_BIT-1:0] SAT_MAX = {2'b00, {(D_BIT-2){1'b1}}};
  localparam logic signed [D_BIT-1:0] SAT_MIN = {2'b11, {(D_BIT-2){1'b0}}};

  // Clamp the outgoing word to the signed D_BIT-1 range
  always_comb begin
    oDATA = raw;
    if ($signed(raw) > SAT_MAX)      oDATA = SAT_MAX;
    else if ($signed(raw) < SAT_MIN) oDATA = SAT_MIN;
  end
`else
  // Raw word passthrough
  always_comb begin
    oDATA = raw;
  end
`endif

endmodule

// File: tb/tb_fht_rd_unload.sv
// Directed bench for fht_rd_unload (D_BIT=16, A_BIT=8, RD_LAT=2) with a
// behavioural 4-bank RAM of two-cycle read latency.
`timescale 1ns/1ps
module tb_fht_rd_unload;

  logic        clk = 1'b0;
  logic        rst, start, fht_rdy, ready;
  logic [7:0]  addr;
  logic [15:0] d0, d1, d2, d3, odata;
  logic [9:0]  oidx;
  logic        ovalid, olast, obusy, odone;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] mem [4][256];
  logic [7:0]         a_q;
  logic [15:0]        got [1024];

  always #5 clk = ~clk;

  // Two-cycle RAM: address registered, then data registered
  always @(posedge clk) begin
    a_q <= addr;
    d0  <= mem[0][a_q];
    d1  <= mem[1][a_q];
    d2  <= mem[2][a_q];
    d3  <= mem[3][a_q];
  end

  fht_rd_unload #(.D_BIT(16), .A_BIT(8), .RD_LAT(2)) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start), .iFHT_RDY(fht_rdy),
    .oADDR_RD(addr), .iDATA_0(d0), .iDATA_1(d1), .iDATA_2(d2), .iDATA_3(d3),
    .oDATA(odata), .oIDX(oidx), .oVALID(ovalid), .iREADY(ready),
    .oLAST(olast), .oBUSY(obusy), .oDONE(odone)
  );

  function automatic logic [15:0] exp_data(input int idx);
    logic signed [15:0] v;
    v = mem[idx % 4][idx / 4];
`ifdef FHT_UNLOAD_SAT_EN
    if (v > 16383) v = 16383;
    else if (v < -16384) v = -16384;
`endif
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; fht_rdy = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    n_tests++; if (odata !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", odata); end
    n_tests++; if (oidx !== 10'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", oidx); end
    n_tests++; if ({ovalid, olast, obusy, odone} !== 4'b0000)
      begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {ovalid, olast, obusy, odone}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full unload; rnd randomises iREADY, mid_start pokes iSTART and drops
  // iFHT_RDY mid-run, chain re-asserts iSTART on the oDONE cycle.
  task automatic test_stream(input bit rnd, input bit mid_start, input bit do_start, input bit chain);
    int cyc = 0, exp_idx = 0, first_v = -1;
    bit stall = 0, fin = 0;
    logic [15:0] h_data; logic [9:0] h_idx; logic h_last;
    if (do_start) begin @(negedge clk); start = 1'b1; fht_rdy = 1'b1; end
    while (!fin && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        n_tests++; if (obusy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b expected 1", obusy); end
      end
      if (mid_start) begin
        if (cyc == 50) fht_rdy = 1'b0;
        start = (cyc == 100);
      end
      if (stall) begin
        n_tests++;
        if (ovalid !== 1'b1 || odata !== h_data || oidx !== h_idx || olast !== h_last) begin
          n_fail++; $display("FAIL stall_hold: got v=%b d=%0d i=%0d l=%b expected v=1 d=%0d i=%0d l=%b",
                             ovalid, odata, oidx, olast, h_data, h_idx, h_last);
        end
      end
      if (odone) begin
        fin = 1;
        n_tests++; if (exp_idx !== 1024) begin n_fail++; $display("FAIL word_count: got %0d expected 1024", exp_idx); end
        n_tests++; if (obusy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b expected 0", obusy); end
        if (chain) begin start = 1'b1; fht_rdy = 1'b1; end
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ovalid && first_v < 0) first_v = cyc;
        if (ovalid && ready) begin
          n_tests++; if (oidx !== 10'(exp_idx)) begin n_fail++; $display("FAIL idx: got %0d expected %0d", oidx, exp_idx); end
          n_tests++; if (odata !== exp_data(exp_idx % 1024))
            begin n_fail++; $display("FAIL data@%0d: got %0d expected %0d", exp_idx, odata, exp_data(exp_idx % 1024)); end
          n_tests++; if (olast !== (exp_idx == 1023))
            begin n_fail++; $display("FAIL last@%0d: got %b expected %b", exp_idx, olast, exp_idx == 1023); end
          if (exp_idx < 1024) got[exp_idx] = odata;
          exp_idx++;
        end
        stall = ovalid && !ready;
        h_data = odata; h_idx = oidx; h_last = olast;
      end
    end
    n_tests++; if (!fin) begin n_fail++; $display("FAIL done_timeout: got no oDONE expected oDONE within 4000 cycles"); end
    n_tests++; if (first_v < 1 || first_v > 4) begin n_fail++; $display("FAIL first_valid: got cycle %0d expected 1..4", first_v); end
    if (!rnd) begin
      n_tests++; if (cyc > 1029) begin n_fail++; $display("FAIL run_length: got %0d expected <= 1029", cyc); end
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk); fht_rdy = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (obusy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b expected 0", obusy); end
    n_tests++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL ignore_valid: got %b expected 0", ovalid); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    @(negedge clk); start = 1'b1; fht_rdy = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(ovalid && oidx == 10'd300) && cyc < 500) begin @(negedge clk); cyc++; end
    n_tests++; if (cyc >= 500) begin n_fail++; $display("FAIL reach_300: got idx %0d expected 300", oidx); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({addr, odata, oidx, ovalid, olast, obusy, odone} !== '0)
      begin n_fail++; $display("FAIL reset_mid: got a=%0d d=%0d i=%0d v=%b l=%b b=%b dn=%b expected all 0",
                               addr, odata, oidx, ovalid, olast, obusy, odone); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (ovalid !== 1'b0 || obusy !== 1'b0)
      begin n_fail++; $display("FAIL post_reset_idle: got v=%b b=%b expected 0 0", ovalid, obusy); end
  endtask

  task automatic test_saturation();
    logic [15:0] e22, e23;
    mem[2][5] = 16'sd20000;
    mem[3][5] = -16'sd20000;
`ifdef FHT_UNLOAD_SAT_EN
    e22 = 16'd16383; e23 = 16'hC000;
`else
    e22 = 16'd20000; e23 = 16'hB1E0;
`endif
    test_stream(1, 0, 1, 0);
    n_tests++; if (got[22] !== e22) begin n_fail++; $display("FAIL sat_22: got %0d expected %0d", $signed(got[22]), $signed(e22)); end
    n_tests++; if (got[23] !== e23) begin n_fail++; $display("FAIL sat_23: got %0d expected %0d", $signed(got[23]), $signed(e23)); end
  endtask

  task automatic test_back_to_back();
    test_stream(0, 0, 1, 1);
    test_stream(0, 0, 0, 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 4; b++)
        mem[b][a] = 16'(4 * a + b);
    test_reset();
    test_stream(0, 0, 1, 0);
    test_stream(1, 1, 1, 0);
    test_ignore_start();
    test_reset_mid();
    test_stream(0, 0, 1, 0);
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
